// File: rtl/assoc_set_array.sv
// N-way set-associative tag/data array with per-set clock (second-chance) replacement.
// Three-cycle request pipeline: IDLE accepts, LOOKUP resolves and updates, RESP publishes.
module assoc_set_array #(
  parameter int unsigned WAYS        = 8,
  parameter int unsigned SETS        = 64,
  parameter int unsigned BLOCK_BYTES = 64,
  parameter int unsigned TAG_W       = 24,
  localparam int unsigned SET_W  = $clog2(SETS),
  localparam int unsigned OFF_W  = $clog2(BLOCK_BYTES),
  localparam int unsigned WAY_W  = $clog2(WAYS),
  localparam int unsigned LINE_W = BLOCK_BYTES * 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [SET_W-1:0]  req_set,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [OFF_W-1:0]  req_offset,
  input  logic [1:0]        req_size,
  input  logic [63:0]       req_wdata,
  input  logic [LINE_W-1:0] fill_data,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              resp_err,
  output logic [WAY_W-1:0]  resp_way,
  output logic [63:0]       resp_rdata,
  output logic              evict_valid,
  output logic [TAG_W-1:0]  evict_tag,
  output logic [SET_W-1:0]  evict_set,
  output logic [LINE_W-1:0] evict_data
);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_FILL  = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_RESP} state_e;

  state_e state_q, state_d;

  logic [1:0]        op_q, op_d, size_q, size_d;
  logic [SET_W-1:0]  set_q, set_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [LINE_W-1:0] fill_q, fill_d;

  logic              pend_hit_q, pend_hit_d, pend_err_q, pend_err_d, pend_evict_q, pend_evict_d;
  logic [WAY_W-1:0]  pend_way_q, pend_way_d;
  logic [63:0]       pend_rdata_q, pend_rdata_d;
  logic [TAG_W-1:0]  pend_etag_q, pend_etag_d;
  logic [LINE_W-1:0] pend_edata_q, pend_edata_d;

  logic              req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic              resp_hit_q, resp_hit_d, resp_err_q, resp_err_d;
  logic [WAY_W-1:0]  resp_way_q, resp_way_d;
  logic [63:0]       resp_rdata_q, resp_rdata_d;
  logic              evict_valid_q, evict_valid_d;
  logic [TAG_W-1:0]  evict_tag_q, evict_tag_d;
  logic [SET_W-1:0]  evict_set_q, evict_set_d;
  logic [LINE_W-1:0] evict_data_q, evict_data_d;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAYS-1:0]   ref_q   [SETS];
  logic [WAY_W-1:0]  hand_q  [SETS];
  logic [TAG_W-1:0]  tag_mem_q  [SETS][WAYS];
  logic [LINE_W-1:0] data_mem_q [SETS][WAYS];

  logic              meta_we, tag_we, data_we;
  logic [WAYS-1:0]   valid_row_d, dirty_row_d, ref_row_d;
  logic [WAY_W-1:0]  hand_d, data_way_d;
  logic [LINE_W-1:0] data_line_d;

  logic [WAYS-1:0]   row_valid, row_dirty, row_ref;
  logic [WAY_W-1:0]  row_hand;
  logic              hit_any, misalign, req_err;
  logic [WAY_W-1:0]  hit_way;
  logic [LINE_W-1:0] hit_line, rd_shift, wmask, wshift;
  logic [63:0]       size_mask;
  logic [2:0]        align_mask;

  assign row_valid = valid_q[set_q];
  assign row_dirty = dirty_q[set_q];
  assign row_ref   = ref_q[set_q];
  assign row_hand  = hand_q[set_q];

  // Tag compare and access geometry for the registered request
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (row_valid[w] && (tag_mem_q[set_q][w] == tag_q)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    unique case (size_q)
      2'd0:    begin size_mask = 64'h0000_0000_0000_00FF; align_mask = 3'd0; end
      2'd1:    begin size_mask = 64'h0000_0000_0000_FFFF; align_mask = 3'd1; end
      2'd2:    begin size_mask = 64'h0000_0000_FFFF_FFFF; align_mask = 3'd3; end
      default: begin size_mask = 64'hFFFF_FFFF_FFFF_FFFF; align_mask = 3'd7; end
    endcase
    misalign = |(offset_q[2:0] & align_mask);
    req_err  = (op_q == 2'd3) || (((op_q == OP_READ) || (op_q == OP_WRITE)) && misalign);
    hit_line = data_mem_q[set_q][hit_way];
    rd_shift = hit_line >> {offset_q, 3'b000};
    wmask    = LINE_W'(size_mask) << {offset_q, 3'b000};
    wshift   = LINE_W'(wdata_q & size_mask) << {offset_q, 3'b000};
  end

  logic              inv_found, scan_found;
  logic [WAY_W-1:0]  inv_way, scan_way, scan_idx, vict;
  logic [WAYS-1:0]   ref_scan, vict_ref_row;

  // Victim: lowest invalid way, else clock sweep from the hand clearing refs it passes
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!row_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    scan_found = 1'b0;
    scan_way   = row_hand;
    scan_idx   = row_hand;
    ref_scan   = row_ref;
    for (int i = 0; i < WAYS; i++) begin
      scan_idx = row_hand + WAY_W'(i);
      if (!scan_found) begin
        if (!row_ref[scan_idx]) begin
          scan_found = 1'b1;
          scan_way   = scan_idx;
        end else begin
          ref_scan[scan_idx] = 1'b0;
        end
      end
    end
    vict         = inv_found ? inv_way : scan_way;
    vict_ref_row = inv_found ? row_ref : ref_scan;
  end

  // Next-state, request capture, array updates and response staging
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    size_d        = size_q;
    set_d         = set_q;
    tag_d         = tag_q;
    offset_d      = offset_q;
    wdata_d       = wdata_q;
    fill_d        = fill_q;
    pend_hit_d    = pend_hit_q;
    pend_err_d    = pend_err_q;
    pend_evict_d  = pend_evict_q;
    pend_way_d    = pend_way_q;
    pend_rdata_d  = pend_rdata_q;
    pend_etag_d   = pend_etag_q;
    pend_edata_d  = pend_edata_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = 1'b0;
    resp_hit_d    = resp_hit_q;
    resp_err_d    = resp_err_q;
    resp_way_d    = resp_way_q;
    resp_rdata_d  = resp_rdata_q;
    evict_valid_d = 1'b0;
    evict_tag_d   = evict_tag_q;
    evict_set_d   = evict_set_q;
    evict_data_d  = evict_data_q;
    meta_we       = 1'b0;
    tag_we        = 1'b0;
    data_we       = 1'b0;
    valid_row_d   = row_valid;
    dirty_row_d   = row_dirty;
    ref_row_d     = row_ref;
    hand_d        = row_hand;
    data_way_d    = hit_way;
    data_line_d   = fill_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d        = req_op;
          size_d      = req_size;
          set_d       = req_set;
          tag_d       = req_tag;
          offset_d    = req_offset;
          wdata_d     = req_wdata;
          fill_d      = fill_data;
          req_ready_d = 1'b0;
          state_d     = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        state_d      = ST_RESP;
        pend_hit_d   = 1'b0;
        pend_err_d   = 1'b0;
        pend_evict_d = 1'b0;
        pend_way_d   = '0;
        pend_rdata_d = '0;
        if (req_err) begin
          pend_err_d = 1'b1;
        end else if (op_q == OP_READ) begin
          if (hit_any) begin
            pend_hit_d         = 1'b1;
            pend_way_d         = hit_way;
            pend_rdata_d       = rd_shift[63:0] & size_mask;
            meta_we            = 1'b1;
            ref_row_d[hit_way] = 1'b1;
          end
        end else if (op_q == OP_WRITE) begin
          if (hit_any) begin
            pend_hit_d           = 1'b1;
            pend_way_d           = hit_way;
            data_we              = 1'b1;
            data_line_d          = (hit_line & ~wmask) | wshift;
            meta_we              = 1'b1;
            dirty_row_d[hit_way] = 1'b1;
            ref_row_d[hit_way]   = 1'b1;
          end
        end else if (op_q == OP_FILL) begin
          meta_we = 1'b1;
          data_we = 1'b1;
          if (hit_any) begin
            pend_hit_d           = 1'b1;
            pend_way_d           = hit_way;
            dirty_row_d[hit_way] = 1'b0;
            ref_row_d[hit_way]   = 1'b1;
          end else begin
            tag_we            = 1'b1;
            data_way_d        = vict;
            pend_way_d        = vict;
            pend_evict_d      = row_valid[vict] && row_dirty[vict];
            pend_etag_d       = tag_mem_q[set_q][vict];
            pend_edata_d      = data_mem_q[set_q][vict];
            valid_row_d[vict] = 1'b1;
            dirty_row_d[vict] = 1'b0;
            ref_row_d         = vict_ref_row;
            ref_row_d[vict]   = 1'b1;
            if (!inv_found) hand_d = vict + WAY_W'(1);
          end
        end
      end
      ST_RESP: begin
        state_d       = ST_IDLE;
        req_ready_d   = 1'b1;
        resp_valid_d  = 1'b1;
        resp_hit_d    = pend_hit_q;
        resp_err_d    = pend_err_q;
        resp_way_d    = pend_way_q;
        resp_rdata_d  = pend_rdata_q;
        evict_valid_d = pend_evict_q;
        if (pend_evict_q) begin
          evict_tag_d  = pend_etag_q;
          evict_set_d  = set_q;
          evict_data_d = pend_edata_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      size_q        <= '0;
      set_q         <= '0;
      tag_q         <= '0;
      offset_q      <= '0;
      wdata_q       <= '0;
      fill_q        <= '0;
      pend_hit_q    <= 1'b0;
      pend_err_q    <= 1'b0;
      pend_evict_q  <= 1'b0;
      pend_way_q    <= '0;
      pend_rdata_q  <= '0;
      pend_etag_q   <= '0;
      pend_edata_q  <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_way_q    <= '0;
      resp_rdata_q  <= '0;
      evict_valid_q <= 1'b0;
      evict_tag_q   <= '0;
      evict_set_q   <= '0;
      evict_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      size_q        <= size_d;
      set_q         <= set_d;
      tag_q         <= tag_d;
      offset_q      <= offset_d;
      wdata_q       <= wdata_d;
      fill_q        <= fill_d;
      pend_hit_q    <= pend_hit_d;
      pend_err_q    <= pend_err_d;
      pend_evict_q  <= pend_evict_d;
      pend_way_q    <= pend_way_d;
      pend_rdata_q  <= pend_rdata_d;
      pend_etag_q   <= pend_etag_d;
      pend_edata_q  <= pend_edata_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_hit_q    <= resp_hit_d;
      resp_err_q    <= resp_err_d;
      resp_way_q    <= resp_way_d;
      resp_rdata_q  <= resp_rdata_d;
      evict_valid_q <= evict_valid_d;
      evict_tag_q   <= evict_tag_d;
      evict_set_q   <= evict_set_d;
      evict_data_q  <= evict_data_d;
    end
  end

  // Replacement metadata: only the addressed set is ever rewritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ref_q[s]   <= '0;
        hand_q[s]  <= '0;
      end
    end else if (meta_we) begin
      valid_q[set_q] <= valid_row_d;
      dirty_q[set_q] <= dirty_row_d;
      ref_q[set_q]   <= ref_row_d;
      hand_q[set_q]  <= hand_d;
    end
  end

  // Tag and data storage carry no reset
  always_ff @(posedge clk) begin
    if (tag_we)  tag_mem_q[set_q][vict]        <= tag_q;
    if (data_we) data_mem_q[set_q][data_way_d] <= data_line_d;
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_err    = resp_err_q;
  assign resp_way    = resp_way_q;
  assign resp_rdata  = resp_rdata_q;
  assign evict_valid = evict_valid_q;
  assign evict_tag   = evict_tag_q;
  assign evict_set   = evict_set_q;
  assign evict_data  = evict_data_q;

endmodule

// File: tb/tb_assoc_set_array.sv
// Scoreboard bench for assoc_set_array: directed requests push expectations,
// a negedge monitor pops and compares on every response strobe.
module tb_assoc_set_array;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [5:0]   req_set;
  logic [23:0]  req_tag;
  logic [5:0]   req_offset;
  logic [1:0]   req_size;
  logic [63:0]  req_wdata;
  logic [511:0] fill_data;
  logic         resp_valid, resp_hit, resp_err, evict_valid;
  logic [2:0]   resp_way;
  logic [63:0]  resp_rdata;
  logic [23:0]  evict_tag;
  logic [5:0]   evict_set;
  logic [511:0] evict_data;

  assoc_set_array dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_set(req_set), .req_tag(req_tag), .req_offset(req_offset),
    .req_size(req_size), .req_wdata(req_wdata), .fill_data(fill_data),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_err(resp_err),
    .resp_way(resp_way), .resp_rdata(resp_rdata), .evict_valid(evict_valid),
    .evict_tag(evict_tag), .evict_set(evict_set), .evict_data(evict_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         hit;
    logic         err;
    logic [2:0]   way;
    logic         chk_way;
    logic [63:0]  rdata;
    logic         chk_rd;
    logic         ev;
    logic [23:0]  etag;
    logic [5:0]   eset;
    logic [511:0] edata;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic hit, input logic err, input logic [2:0] way,
                              input logic chk_way, input logic [63:0] rdata, input logic chk_rd);
    exp_t e;
    e.hit = hit; e.err = err; e.way = way; e.chk_way = chk_way;
    e.rdata = rdata; e.chk_rd = chk_rd;
    e.ev = 1'b0; e.etag = '0; e.eset = '0; e.edata = '0; e.acc = 0;
    return e;
  endfunction

  function automatic logic [511:0] pat(input logic [7:0] b);
    return {64{b}};
  endfunction

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 512'(resp_valid), 512'(0));
      end else begin
        e = exp_q.pop_front();
        chk("latency", 512'(cyc - e.acc), 512'(2));
        chk("resp_hit", 512'(resp_hit), 512'(e.hit));
        chk("resp_err", 512'(resp_err), 512'(e.err));
        if (e.chk_way) chk("resp_way", 512'(resp_way), 512'(e.way));
        if (e.chk_rd)  chk("resp_rdata", 512'(resp_rdata), 512'(e.rdata));
        chk("evict_valid", 512'(evict_valid), 512'(e.ev));
        if (e.ev) begin
          chk("evict_tag", 512'(evict_tag), 512'(e.etag));
          chk("evict_set", 512'(evict_set), 512'(e.eset));
          chk("evict_data", evict_data, e.edata);
        end
      end
    end
    if (rst_n === 1'b1 && evict_valid === 1'b1 && resp_valid !== 1'b1)
      chk("evict_without_resp", 512'(resp_valid), 512'(1));
  end

  task automatic issue(input logic [1:0] op, input logic [5:0] set, input logic [23:0] tag,
                       input logic [5:0] off, input logic [1:0] size, input logic [63:0] wd,
                       input logic [511:0] fd, input exp_t e, input bit want_resp);
    int   n;
    exp_t ee;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      chk("ready_timeout", 512'(req_ready), 512'(1));
      return;
    end
    req_op = op; req_set = set; req_tag = tag; req_offset = off;
    req_size = size; req_wdata = wd; fill_data = fd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ee = e;
    ee.acc = cyc;
    if (want_resp) exp_q.push_back(ee);
  endtask

  task automatic rd(input logic [5:0] set, input logic [23:0] tag, input logic [5:0] off,
                    input logic [1:0] size, input exp_t e);
    issue(2'd0, set, tag, off, size, 64'd0, '0, e, 1'b1);
  endtask

  task automatic wr(input logic [5:0] set, input logic [23:0] tag, input logic [5:0] off,
                    input logic [1:0] size, input logic [63:0] wd, input exp_t e);
    issue(2'd1, set, tag, off, size, wd, '0, e, 1'b1);
  endtask

  task automatic fl(input logic [5:0] set, input logic [23:0] tag, input logic [511:0] fd,
                    input exp_t e);
    issue(2'd2, set, tag, 6'd0, 2'd0, 64'd0, fd, e, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 512'(exp_q.size()), 512'(0));
  endtask

  initial begin
    logic [511:0] line5;
    logic [511:0] ed;
    exp_t e;

    for (int k = 0; k < 64; k++) line5[8*k +: 8] = 8'(k);
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_set = '0; req_tag = '0;
    req_offset = '0; req_size = '0; req_wdata = '0; fill_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 512'(req_ready), 512'(1));
    chk("rst_resp_valid", 512'(resp_valid), 512'(0));
    chk("rst_resp_hit", 512'(resp_hit), 512'(0));
    chk("rst_resp_rdata", 512'(resp_rdata), 512'(0));
    chk("rst_evict_valid", 512'(evict_valid), 512'(0));
    chk("rst_evict_data", evict_data, 512'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Set 5: fill, read, partial write, alignment errors, misses
    fl(6'd5, 24'h1, line5, mk(1'b0, 1'b0, 3'd0, 1'b1, 64'd0, 1'b0));
    rd(6'd5, 24'h1, 6'd8, 2'd3, mk(1'b1, 1'b0, 3'd0, 1'b1, 64'h0F0E_0D0C_0B0A_0908, 1'b1));
    wr(6'd5, 24'h1, 6'd2, 2'd1, 64'hBEEF, mk(1'b1, 1'b0, 3'd0, 1'b1, 64'd0, 1'b0));
    rd(6'd5, 24'h1, 6'd0, 2'd2, mk(1'b1, 1'b0, 3'd0, 1'b1, 64'hBEEF_0100, 1'b1));
    rd(6'd5, 24'h1, 6'd3, 2'd2, mk(1'b0, 1'b1, 3'd0, 1'b0, 64'd0, 1'b0));
    wr(6'd5, 24'h1, 6'd1, 2'd1, 64'h1234, mk(1'b0, 1'b1, 3'd0, 1'b0, 64'd0, 1'b0));
    rd(6'd5, 24'h1, 6'd0, 2'd3, mk(1'b1, 1'b0, 3'd0, 1'b1, 64'h0706_0504_BEEF_0100, 1'b1));
    rd(6'd5, 24'h1, 6'd1, 2'd0, mk(1'b1, 1'b0, 3'd0, 1'b1, 64'h01, 1'b1));
    wr(6'd5, 24'h7, 6'd0, 2'd3, 64'hDEAD, mk(1'b0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b0));
    rd(6'd5, 24'h7, 6'd0, 2'd3, mk(1'b0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b1));
    issue(2'd3, 6'd5, 24'h1, 6'd0, 2'd0, 64'd0, '0, mk(1'b0, 1'b1, 3'd0, 1'b0, 64'd0, 1'b0), 1'b1);
    fl(6'd5, 24'h1, pat(8'h55), mk(1'b1, 1'b0, 3'd0, 1'b1, 64'd0, 1'b0));
    rd(6'd5, 24'h1, 6'd8, 2'd3, mk(1'b1, 1'b0, 3'd0, 1'b1, 64'h5555_5555_5555_5555, 1'b1));

    // Set 0: fill all ways, dirty way 0, then exercise the clock sweep
    for (int t = 1; t <= 8; t++)
      fl(6'd0, 24'(t), pat(8'(t)), mk(1'b0, 1'b0, 3'(t - 1), 1'b1, 64'd0, 1'b0));
    wr(6'd0, 24'h1, 6'd0, 2'd0, 64'hAA, mk(1'b1, 1'b0, 3'd0, 1'b1, 64'd0, 1'b0));
    ed = pat(8'h01);
    ed[7:0] = 8'hAA;
    e = mk(1'b0, 1'b0, 3'd0, 1'b1, 64'd0, 1'b0);
    e.ev = 1'b1; e.etag = 24'h1; e.eset = 6'd0; e.edata = ed;
    fl(6'd0, 24'h9, pat(8'h09), e);
    rd(6'd0, 24'h2, 6'd0, 2'd3, mk(1'b1, 1'b0, 3'd1, 1'b1, 64'h0202_0202_0202_0202, 1'b1));
    fl(6'd0, 24'hA, pat(8'h0A), mk(1'b0, 1'b0, 3'd2, 1'b1, 64'd0, 1'b0));
    fl(6'd0, 24'hB, pat(8'h0B), mk(1'b0, 1'b0, 3'd3, 1'b1, 64'd0, 1'b0));
    rd(6'd0, 24'h3, 6'd0, 2'd3, mk(1'b0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b1));
    rd(6'd0, 24'h9, 6'd0, 2'd3, mk(1'b1, 1'b0, 3'd0, 1'b1, 64'h0909_0909_0909_0909, 1'b1));
    rd(6'd5, 24'h1, 6'd0, 2'd1, mk(1'b1, 1'b0, 3'd0, 1'b1, 64'h5555, 1'b1));
    drain();

    // Reset while a fill sits in LOOKUP: no response, no eviction, all state cleared
    issue(2'd2, 6'd0, 24'hC, 6'd0, 2'd0, 64'd0, pat(8'h0C),
          mk(1'b0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b0), 1'b0);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_resp_valid", 512'(resp_valid), 512'(0));
      chk("abort_evict_valid", 512'(evict_valid), 512'(0));
      chk("abort_req_ready", 512'(req_ready), 512'(1));
    end
    rst_n = 1'b1;
    rd(6'd5, 24'h1, 6'd0, 2'd3, mk(1'b0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b1));
    rd(6'd0, 24'h9, 6'd0, 2'd3, mk(1'b0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b1));
    rd(6'd0, 24'hC, 6'd0, 2'd3, mk(1'b0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b1));
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/assoc_set_array.md
Name: assoc_set_array

Overview:
Parametrised N-way set-associative cache data/tag array, next generation of the fixed 8-way set block. Handles read hit, write hit and line fill. Replacement is per-set clock (second-chance) with valid, dirty and reference bits. Sits between the cache controller, which issues requests and handles misses, and the next memory level, which receives dirty evictions.

Parameters:
WAYS, 8, associativity (power of 2, 2..16)
SETS, 64, number of sets (power of 2)
BLOCK_BYTES, 64, line size in bytes (power of 2, >= 8)
TAG_W, 24, tag width in bits
Derived: SET_W = log2(SETS), OFF_W = log2(BLOCK_BYTES), WAY_W = log2(WAYS), LINE_W = BLOCK_BYTES*8

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  array can accept a request
req_op  in  2  0 = read, 1 = write, 2 = fill, 3 = reserved (treated as error)
req_set  in  SET_W  set index
req_tag  in  TAG_W  tag
req_offset  in  OFF_W  byte offset within line
req_size  in  2  access size: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B
req_wdata  in  64  write data, right-aligned
fill_data  in  LINE_W  full line for fill
resp_valid  out  1  one-cycle response strobe
resp_hit  out  1  tag matched a valid way
resp_err  out  1  misaligned access or reserved op
resp_way  out  WAY_W  way hit or way filled
resp_rdata  out  64  read data, zero-extended
evict_valid  out  1  one-cycle strobe: dirty victim displaced
evict_tag  out  TAG_W  victim tag
evict_set  out  SET_W  victim set
evict_data  out  LINE_W  victim line contents

Behaviour:
- Reset, asynchronous, while rst_n = 0:
  - All valid, dirty and reference bits clear; per-set clock hands = 0; FSM goes to IDLE.
  - Outputs: req_ready = 1; all other outputs = 0.
  - Tag and data storage are not reset.
  - Reset during LOOKUP or RESP aborts the operation with no response and no eviction.
- FSM: IDLE -> LOOKUP -> RESP -> IDLE.
  - req_ready = 1 only in IDLE.
  - A request is accepted on the edge where req_valid and req_ready are both 1; all request fields are registered at that edge.
  - LOOKUP: tag compare, victim selection and state update.
  - RESP: resp_valid = 1 for exactly one cycle; response outputs hold until the next response.
  - Latency: accepted at edge N, resp_valid high in the cycle following edge N+2. Back-to-back throughput is one request per 3 cycles.
- Hit: tag equal AND valid. At most one way can match; fill guarantees no duplicate tags.
- Alignment: error when req_offset is not a multiple of 2^req_size, or when req_op = 3.
  - Response: resp_err = 1, resp_hit = 0, no state change.
  - Checked for read and write only; fill ignores offset and size.
- Byte layout is little-endian: byte k of the line occupies bits [8k+7:8k].
- Read hit: resp_rdata = bytes [offset, offset + 2^size), zero-extended; set ref bit of the hit way.
- Read miss: resp_hit = 0, resp_rdata = 0, no state change.
- Write hit: replace only the addressed bytes with the low 2^size bytes of req_wdata; set dirty and ref bits.
- Write miss: no allocate; resp_hit = 0, no state change.
- Fill, tag already present: overwrite that way with fill_data; dirty = 0, ref = 1; resp_hit = 1; no eviction.
- Fill, tag absent: victim selection, in order:
  1. Lowest-numbered invalid way.
  2. Otherwise scan ways cyclically starting at the set's hand. The first way with ref = 0 is the victim; ref bits of ways skipped over are cleared.
  3. If all refs are 1: clear all refs in the set; victim = hand.
  - After fill, hand = (victim + 1) mod WAYS, except in case 1 where the hand is unchanged.
  - Victim becomes valid = 1, dirty = 0, ref = 1, tag = req_tag, data = fill_data; resp_hit = 0, resp_way = victim.
  - If the victim was valid and dirty: evict_valid = 1 in the same cycle as resp_valid, with the victim's old tag, set and data.
- Only the addressed set's bits and hand change on any operation.

Test Plan:
- Reset, then fill set 5 with tag 0x1 and fill_data bytes 0..63 = 0x00..0x3F; read set 5, tag 0x1, offset 8, size 3 -> resp_hit = 1, resp_way = 0, resp_rdata = 0x0F0E0D0C0B0A0908, resp_valid exactly 2 cycles after accept.
- Write set 5, tag 0x1, offset 2, size 1, wdata 0xBEEF; read offset 0, size 2 -> rdata = 0xBEEF0100, resp_hit = 1.
- Read offset 3 size 2 -> resp_err = 1, no change; write tag 0x7 (miss) -> resp_hit = 0, later read of 0x7 still misses.
- Fill tags 0x1..0x8 into set 0 (ways 0..7), dirty way 0 with a write, fill tag 0x9 -> all refs set so victim = way 0, evict_valid = 1, evict_tag = 0x1, hand = 1, resp_way = 0.
- Continue: read tag 0x2 (way 1, ref = 1), fill 0xA -> way 1 skipped and ref cleared, victim = way 2, evict_valid = 0 (clean).
- Assert rst_n low during LOOKUP of a fill -> no resp_valid, no evict_valid; afterwards every read misses and req_ready = 1.
